sid_envelope: RTL and testbench

- ADSR envelope generator and amplitude stage for one SID voice, placed directly downstream of the voice oscillator/waveform block.
- Takes the voice's 12-bit unsigned waveform, generates an 8-bit envelope from the gate and ADSR registers, and outputs the signed product to the mixer.
- Decodes its own registers from the shared 5-bit SID bus.

---
 rtl/sid_envelope.sv | 131 +++++++++++++
 tb/tb_sid_envelope.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sid_envelope.sv
// sid_envelope: SID voice ADSR envelope and amplitude stage.
// Define SID_ENV_ADSR_BUG_EN to reproduce the real-SID equality-only rate counter match.
module sid_envelope #(
  parameter logic [4:0] BASE_ADDR = 5'd0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLKen,
  input  logic               WR,
  input  logic [4:0]         ADDR,
  input  logic [7:0]         DATA,
  input  logic [11:0]        WAVE_IN,
  output logic [7:0]         ENV_OUT,
  output logic signed [19:0] OUTPUT
);
  typedef enum logic [1:0] {ATTACK, DECAY_SUSTAIN, RELEASE} state_t;
  state_t      r_state, w_state_nx;
  logic        r_gate, r_gate_lag;
  logic [3:0]  r_atk, r_dec, r_sus, r_rel, w_rate_sel;
  logic [14:0] r_rate_cnt, w_period;
  logic [4:0]  r_exp_cnt, w_exp_nx, w_exp_per;
  logic [7:0]  r_env, w_env_nx, r_env_d;
  logic [11:0] r_s;
  logic [19:0] w_prod;
  logic        w_tick, w_rise, w_fall, w_exp_hit, w_wr4, w_wr5, w_wr6;

  assign w_wr4 = WR && (ADDR == BASE_ADDR + 5'd4);
  assign w_wr5 = WR && (ADDR == BASE_ADDR + 5'd5);
  assign w_wr6 = WR && (ADDR == BASE_ADDR + 5'd6);

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_gate <= 1'b0;
      {r_atk, r_dec, r_sus, r_rel} <= 16'd0;
    end else begin
      if (w_wr4) r_gate <= DATA[0];
      if (w_wr5) {r_atk, r_dec} <= DATA;
      if (w_wr6) {r_sus, r_rel} <= DATA;
    end

  assign w_rate_sel = r_state == ATTACK ? r_atk : r_state == DECAY_SUSTAIN ? r_dec : r_rel;

  always_comb
    case (w_rate_sel)
      4'd0:    w_period = 15'd9;
      4'd1:    w_period = 15'd32;
      4'd2:    w_period = 15'd63;
      4'd3:    w_period = 15'd95;
      4'd4:    w_period = 15'd149;
      4'd5:    w_period = 15'd220;
      4'd6:    w_period = 15'd267;
      4'd7:    w_period = 15'd313;
      4'd8:    w_period = 15'd392;
      4'd9:    w_period = 15'd977;
      4'd10:   w_period = 15'd1954;
      4'd11:   w_period = 15'd3126;
      4'd12:   w_period = 15'd3907;
      4'd13:   w_period = 15'd11720;
      4'd14:   w_period = 15'd19532;
      default: w_period = 15'd31251;
    endcase

`ifdef SID_ENV_ADSR_BUG_EN
  // a counter already past the new period free-runs through the 15-bit wrap
  assign w_tick = r_rate_cnt == w_period;
`else
  assign w_tick = r_rate_cnt >= w_period;
`endif

  assign w_exp_per = r_env >= 8'd94 ? 5'd1  :
                     r_env >= 8'd54 ? 5'd2  :
                     r_env >= 8'd26 ? 5'd4  :
                     r_env >= 8'd14 ? 5'd8  :
                     r_env >= 8'd6  ? 5'd16 :
                     r_env != 8'd0  ? 5'd30 : 5'd1;
  assign w_exp_hit = r_exp_cnt == w_exp_per - 5'd1;
  assign w_rise    = r_gate & ~r_gate_lag;
  assign w_fall    = ~r_gate & r_gate_lag;

  // gate edges take priority over a coincident tick
  always_comb begin
    w_state_nx = r_state;
    w_env_nx   = r_env;
    w_exp_nx   = (r_state == RELEASE && r_env == 8'd0) ? 5'd0 : r_exp_cnt;
    if (w_rise) w_state_nx = ATTACK;
    else if (w_fall) w_state_nx = RELEASE;
    else if (w_tick)
      case (r_state)
        ATTACK: begin
          w_exp_nx = 5'd0;
          w_env_nx = r_env == 8'hFF ? r_env : r_env + 8'd1;
          if (r_env >= 8'hFE) w_state_nx = DECAY_SUSTAIN;
        end
        DECAY_SUSTAIN:
          if (r_env > {r_sus, r_sus}) {w_exp_nx, w_env_nx} = w_exp_hit ? {5'd0, r_env - 8'd1} : {r_exp_cnt + 5'd1, r_env};
        default:
          if (r_env != 8'd0) {w_exp_nx, w_env_nx} = w_exp_hit ? {5'd0, r_env - 8'd1} : {r_exp_cnt + 5'd1, r_env};
      endcase
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state    <= RELEASE;
      r_gate_lag <= 1'b0;
      r_rate_cnt <= 15'd0;
      r_exp_cnt  <= 5'd0;
      r_env      <= 8'd0;
    end else if (CLKen) begin
      r_state    <= w_state_nx;
      r_gate_lag <= r_gate;
      r_rate_cnt <= w_tick ? 15'd0 : r_rate_cnt + 15'd1;
      r_exp_cnt  <= w_exp_nx;
      r_env      <= w_env_nx;
    end

  assign ENV_OUT = r_env;

  // low 20 bits of the extended unsigned product equal the signed product
  assign w_prod = {{8{r_s[11]}}, r_s} * {12'd0, r_env_d};

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_s     <= 12'd0;
      r_env_d <= 8'd0;
      OUTPUT  <= 20'sd0;
    end else begin
      r_s     <= {~WAVE_IN[11], WAVE_IN[10:0]};
      r_env_d <= r_env;
      OUTPUT  <= $signed(w_prod);
    end
endmodule

// File: tb/tb_sid_envelope.sv
// tb_sid_envelope: scoreboard bench for sid_envelope with directed ADSR and amplitude vectors.
module tb_sid_envelope;
  logic               CLK = 1'b0, RST, CLKen, WR;
  logic [4:0]         ADDR;
  logic [7:0]         DATA;
  logic [11:0]        WAVE_IN;
  logic [7:0]         ENV_OUT;
  logic signed [19:0] OUTPUT;

  typedef struct {string name; int exp; bit is_out;} chk_t;
  chk_t q[$];
  chk_t c;
  int   n_chk = 0, n_pass = 0, en_cnt = 0, act;
  bit   done = 1'b0;

  sid_envelope dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .WAVE_IN(WAVE_IN), .ENV_OUT(ENV_OUT), .OUTPUT(OUTPUT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    while (q.size() > 0) begin
      c   = q.pop_front();
      act = c.is_out ? int'(OUTPUT) : int'(ENV_OUT);
      n_chk++;
      if (act == c.exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
    end

  initial begin
    #5000000;
    n_chk++;
    if (done) n_pass++;
    else begin
      $display("FAIL timeout: bench did not finish within wait limit");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  task automatic chk(input string n, input int v, input bit o);
    q.push_back('{n, v, o});
    @(negedge CLK);
    #1;
  endtask

  task automatic en1;
    CLKen = 1'b1;
    @(posedge CLK);
    #1;
    CLKen = 1'b0;
    en_cnt++;
  endtask

  task automatic run_to(input int t);
    while (en_cnt < t) en1();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DATA = d;
    @(posedge CLK);
    #1;
    WR = 1'b0;
  endtask

  initial begin
    RST = 1'b1; CLKen = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0; WAVE_IN = 12'hFFF;
    idle(3);
    n_chk++;
    if (ENV_OUT === 8'd0 && OUTPUT === 20'sd0) n_pass++;
    else $display("FAIL reset_state: ENV_OUT=%0d OUTPUT=%0d", ENV_OUT, OUTPUT);
    chk("reset_env", 0, 0);
    chk("reset_out", 0, 1);
    RST = 1'b0;
    wr(5'd5, 8'h00);
    wr(5'd6, 8'hA0);
    wr(5'd4, 8'h01);
    run_to(5);    chk("attack_en5", 0, 0);
    run_to(10);   chk("attack_first_tick", 1, 0);
    idle(30);     chk("clken_low_hold", 1, 0);
    run_to(19);   chk("attack_en19", 1, 0);
    run_to(20);   chk("attack_en20", 2, 0);
    run_to(2549); chk("attack_en2549", 254, 0);
    run_to(2550); chk("attack_peak", 255, 0);
    idle(2);      chk("amp_max_pos", 521985, 1);
    WAVE_IN = 12'h000;
    idle(1);      chk("amp_latency_old", 521985, 1);
    idle(1);      chk("amp_max_neg", -522240, 1);
    WAVE_IN = 12'h800;
    idle(2);      chk("amp_centre", 0, 1);
    WAVE_IN = 12'hC00;
    idle(2);      chk("amp_quarter", 261120, 1);
    run_to(2559); chk("peak_hold", 255, 0);
    run_to(2560); chk("decay_first", 254, 0);
    run_to(3400); chk("sustain_reach", 170, 0);
    run_to(3500); chk("sustain_hold", 170, 0);
    WAVE_IN = 12'hFFF;
    idle(2);      chk("amp_sus_pos", 347990, 1);
    WAVE_IN = 12'h001;
    idle(2);      chk("amp_sus_neg", -347990, 1);
    wr(5'd4, 8'h00);
    run_to(3501); chk("release_edge", 170, 0);
    run_to(3510); chk("release_first", 169, 0);
    run_to(4270); chk("release_93", 93, 0);
    run_to(4280); chk("release_93_hold", 93, 0);
    run_to(4290); chk("release_92", 92, 0);
    run_to(8430); chk("release_5", 5, 0);
    run_to(8729); chk("release_5_hold", 5, 0);
    run_to(8730); chk("release_4", 4, 0);
    run_to(9929); chk("release_1", 1, 0);
    run_to(9930); chk("release_0", 0, 0);
    run_to(10430); chk("release_floor", 0, 0);
    wr(5'd4, 8'h01);
    run_to(10830); chk("reattack_40", 40, 0);
    wr(5'd4, 8'h00);
    run_to(10831);
    wr(5'd4, 8'h01);
    run_to(10832); chk("retrigger_keep", 40, 0);
    run_to(10840); chk("retrigger_step", 41, 0);
    run_to(10849);
    wr(5'd4, 8'h00);
    run_to(10850); chk("edge_beats_tick", 41, 0);
    run_to(10880); chk("rel_e4_hold", 41, 0);
    run_to(10890); chk("rel_e4_step", 40, 0);
    WAVE_IN = 12'hFFF;
    wr(5'd4, 8'h01);
    run_to(10905); chk("pre_reset_env", 41, 0);
    chk("pre_reset_out", 83927, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    chk("async_rst_env", 0, 0);
    chk("async_rst_out", 0, 1);
    idle(2);
    RST = 1'b0;
    en_cnt = 0;
    run_to(100); chk("post_rst_env", 0, 0);
    chk("post_rst_out", 0, 1);
    en_cnt = 0;
    wr(5'd5, 8'hF0);
    wr(5'd4, 8'h01);
    run_to(20000); chk("slow_attack_idle", 0, 0);
    wr(5'd5, 8'h00);
`ifdef SID_ENV_ADSR_BUG_EN
    run_to(20001); chk("bug_no_early_tick", 0, 0);
    run_to(32777); chk("bug_pre_wrap_tick", 0, 0);
    run_to(32778); chk("bug_wrap_tick", 1, 0);
`else
    run_to(20001); chk("short_next_tick", 1, 0);
    run_to(20010); chk("short_hold", 1, 0);
    run_to(20011); chk("short_second", 2, 0);
`endif
    done = 1'b1;
    n_chk++;
    n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
